btb_bht_sa: RTL and testbench
=============================

BTB_BHT_SA -- requirements
Module: btb_bht_sa

Interface
REQ-001 SHALL have parameter SET_BITS, default 4, meaning log2 of the number of sets.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; power of two, 1..8.
REQ-003 SHALL have parameter CTR_BITS, default 2, meaning the width of each entry's saturating counter; range 1..4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port if_pc, input, 32, the fetch PC for lookup.
REQ-007 SHALL have port mem_pc, input, 32, the PC of the resolved control-flow instruction in MEM.
REQ-008 SHALL have port mem_target, input, 32, the resolved target address.
REQ-009 SHALL have port mem_update, input, 1, asserted when MEM holds a resolved branch or jump.
REQ-010 SHALL have port mem_taken, input, 1, the resolved direction.
REQ-011 SHALL have port mem_is_jal, input, 1, asserted when the MEM instruction is jal.
REQ-012 SHALL have port flush_req, input, 1, a single-cycle request to invalidate all entries.
REQ-013 SHALL have port flush_busy, output, 1, asserted while the invalidate sweep runs.
REQ-014 SHALL have port hit, output, 1, asserted when if_pc matches a valid entry.
REQ-015 SHALL have port prediction, output, 1, the predicted-taken flag for if_pc.
REQ-016 SHALL have port target_out, output, 32, the predicted target address.
REQ-017 SHALL have port is_jal, output, 1, the stored jal flag of the hitting entry.

Function
REQ-018 Index SHALL be pc[SET_BITS+1:2] and tag SHALL be pc[31:SET_BITS+2], for both if_pc and mem_pc.
REQ-019 Lookup SHALL be combinational; hit, prediction, target_out and is_jal SHALL be 0 on a miss or while flush_busy=1.
REQ-020 prediction SHALL equal the counter MSB, except that it SHALL be 1 for any hitting entry with is_jal=1.
REQ-021 If multiple ways hit, the lowest-numbered way SHALL win.
REQ-022 On mem_update with a MEM hit, the counter SHALL saturate-increment if taken and saturate-decrement otherwise, and the hit way SHALL become PLRU most-recent.
REQ-023 On mem_update with a MEM hit and mem_taken=1, the target SHALL be overwritten with mem_target (covers jalr retargeting).
REQ-024 On mem_update with a MEM miss and mem_taken=1, the block SHALL allocate: the victim is the lowest invalid way, else the PLRU victim.
REQ-025 An allocated entry SHALL be written with tag, target, is_jal, valid=1 and counter=2^(CTR_BITS-1) (weakly taken), and the victim SHALL become most-recent.
REQ-026 On mem_update with a MEM miss and mem_taken=0, no state SHALL change.
REQ-027 Writes SHALL become visible to lookup on the next cycle; a same-cycle IF lookup of the written set SHALL see the old contents.
REQ-028 The flush FSM SHALL have states IDLE and SWEEP.
REQ-029 In IDLE, flush_req=1 SHALL move the FSM to SWEEP with the set pointer at 0.
REQ-030 In SWEEP, the FSM SHALL clear valid and PLRU state of one set per cycle, incrementing the pointer, and SHALL return to IDLE after set 2^SET_BITS-1, taking 2^SET_BITS cycles in total.
REQ-031 flush_busy SHALL be 1 exactly while in SWEEP.
REQ-032 In SWEEP, flush_req and mem_update SHALL be ignored.
REQ-033 flush_req and mem_update in the same IDLE cycle: the update SHALL be discarded and the sweep SHALL start.
REQ-034 With WAYS=1, PLRU SHALL be absent and the victim SHALL always be way 0.

Reset
REQ-035 rst_n=0 SHALL immediately clear all valid bits, counters, targets, tags and PLRU bits, and set FSM=IDLE and pointer=0.
REQ-036 During and after reset, all outputs SHALL be 0 until a valid allocation exists.
REQ-037 Reset asserted mid-SWEEP SHALL abort the sweep; the FSM SHALL be IDLE on release.

Structure
REQ-038 The flush FSM state enum and the default parameter values SHALL reside in package rv32i_types; the entry struct SHALL be module-local because it is parameter-dependent.
REQ-039 Tree pseudo-LRU SHALL be a sub-module btb_plru #(WAYS), instantiated once per set, with inputs touch_en and touch_way and output victim_way.

Verification
REQ-040 Defaults: update pc=0x100, target=0x200, taken=1 -> next-cycle lookup 0x100 gives hit=1, target_out=0x200, prediction=1.
REQ-041 Defaults: same pc updated not-taken twice -> prediction=0; then taken twice -> prediction=1; counter saturates at 0 and 3.
REQ-042 Defaults: allocate 0x100, 0x140, 0x180 (same set 0) -> 0x100 evicted, others hit.
REQ-043 jal entry at 0x300 after four not-taken updates -> prediction stays 1 and is_jal=1.
REQ-044 flush_req with 16 sets -> flush_busy high exactly 16 cycles, hit=0 throughout and after; mem_update during the sweep leaves no entry.
REQ-045 rst_n dropped at sweep cycle 5 -> all outputs 0 immediately; flush_busy=0 after release.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and default sizing for the branch target buffer / history table.
package rv32i_types;

   localparam int BTB_SET_BITS = 4;
   localparam int BTB_WAYS     = 2;
   localparam int BTB_CTR_BITS = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } flush_state_e;

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU for one set: a heap of WAYS-1 direction bits, bit=0 points the victim left.
module btb_plru #(
   parameter  int WAYS = 2,
   localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          touch_en,
   input  logic [WB-1:0] touch_way,
   output logic [WB-1:0] victim_way
);

   generate
      if (WAYS == 1) begin : g_none
         logic w_unused;
         assign w_unused   = ^{clk, rst_n, clr, touch_en, touch_way};
         assign victim_way = '0;
      end else begin : g_tree
         localparam int LVLS = $clog2(WAYS);

         logic [WAYS-1:1] r_tree;
         logic [WAYS-1:1] w_tree_nxt;

         always_comb begin
            int node;
            node = 1;
            for (int l = 0; l < LVLS; l++) begin
               node = 2 * node + int'(r_tree[node]);
            end
            victim_way = WB'(node - WAYS);
         end

         // Walk the touched way's path and point every node on it away from that way.
         always_comb begin
            int node;
            w_tree_nxt = r_tree;
            node       = 1;
            for (int l = 0; l < LVLS; l++) begin
               w_tree_nxt[node] = ~touch_way[LVLS-1-l];
               node = 2 * node + int'(touch_way[LVLS-1-l]);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tree <= '0;
            end else if (clr) begin
               r_tree <= '0;
            end else if (touch_en) begin
               r_tree <= w_tree_nxt;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/btb_bht_sa.sv
// Set-associative BTB with per-entry saturating direction counters and a sweeping flush.
module btb_bht_sa
   import rv32i_types::*;
#(
   parameter int SET_BITS = BTB_SET_BITS,
   parameter int WAYS     = BTB_WAYS,
   parameter int CTR_BITS = BTB_CTR_BITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  if_pc,
   input  logic [31:0]  mem_pc,
   input  logic [31:0]  mem_target,
   input  logic         mem_update,
   input  logic         mem_taken,
   input  logic         mem_is_jal,
   input  logic         flush_req,
   output logic         flush_busy,
   output logic         hit,
   output logic         prediction,
   output logic [31:0]  target_out,
   output logic         is_jal,
   output flush_state_e dbg_state
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = 30 - SET_BITS;
   localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      logic [31:0]         target;
      logic                is_jal;
      logic [CTR_BITS-1:0] ctr;
   } entry_t;

   entry_t              r_ent [SETS][WAYS];
   flush_state_e        r_state, w_state_nxt;
   logic [SET_BITS-1:0] r_ptr, w_ptr_nxt;

   logic [SET_BITS-1:0] w_if_idx, w_mem_idx;
   logic [TAG_W-1:0]    w_if_tag, w_mem_tag;
   logic                w_sweep, w_upd, w_alloc, w_touch;
   logic                w_mem_hit, w_inv_found;
   logic [WB-1:0]       w_mem_way, w_inv_way, w_wr_way;
   logic [WB-1:0]       w_victim [SETS];
   logic                w_unused;

   assign w_if_idx  = if_pc[SET_BITS+1:2];
   assign w_if_tag  = if_pc[31:SET_BITS+2];
   assign w_mem_idx = mem_pc[SET_BITS+1:2];
   assign w_mem_tag = mem_pc[31:SET_BITS+2];
   assign w_unused  = ^{if_pc[1:0], mem_pc[1:0]};

   assign w_sweep    = (r_state == SWEEP);
   assign flush_busy = w_sweep;
   assign dbg_state  = r_state;

   // A flush request wins over an update arriving in the same cycle.
   assign w_upd   = mem_update & ~w_sweep & ~flush_req;
   assign w_alloc = w_upd & ~w_mem_hit & mem_taken;
   assign w_touch = w_upd & (w_mem_hit | mem_taken);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (flush_req) begin
               w_state_nxt = SWEEP;
               w_ptr_nxt   = '0;
            end
         end
         SWEEP: begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (&r_ptr) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Descending scan so the lowest-numbered hitting way is the one left driving the outputs.
   always_comb begin
      hit        = 1'b0;
      prediction = 1'b0;
      target_out = '0;
      is_jal     = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!w_sweep && r_ent[w_if_idx][w].valid && (r_ent[w_if_idx][w].tag == w_if_tag)) begin
            hit        = 1'b1;
            target_out = r_ent[w_if_idx][w].target;
            is_jal     = r_ent[w_if_idx][w].is_jal;
            prediction = r_ent[w_if_idx][w].ctr[CTR_BITS-1] | r_ent[w_if_idx][w].is_jal;
         end
      end
   end

   always_comb begin
      w_mem_hit   = 1'b0;
      w_mem_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_ent[w_mem_idx][w].valid && (r_ent[w_mem_idx][w].tag == w_mem_tag)) begin
            w_mem_hit = 1'b1;
            w_mem_way = WB'(w);
         end
         if (!r_ent[w_mem_idx][w].valid) begin
            w_inv_found = 1'b1;
            w_inv_way   = WB'(w);
         end
      end
   end

   assign w_wr_way = w_mem_hit   ? w_mem_way :
                     w_inv_found ? w_inv_way : w_victim[w_mem_idx];

   generate
      for (genvar s = 0; s < SETS; s++) begin : g_set
         btb_plru #(.WAYS(WAYS)) u_plru (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (w_sweep && (r_ptr == SET_BITS'(s))),
            .touch_en  (w_touch && (w_mem_idx == SET_BITS'(s))),
            .touch_way (w_wr_way),
            .victim_way(w_victim[s])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_ent[s][w] <= '0;
            end
         end
      end else if (w_sweep) begin
         for (int w = 0; w < WAYS; w++) begin
            r_ent[r_ptr][w].valid <= 1'b0;
         end
      end else if (w_upd && w_mem_hit) begin
         if (mem_taken) begin
            r_ent[w_mem_idx][w_mem_way].target <= mem_target;
            if (r_ent[w_mem_idx][w_mem_way].ctr != '1)
               r_ent[w_mem_idx][w_mem_way].ctr <= r_ent[w_mem_idx][w_mem_way].ctr + 1'b1;
         end else if (r_ent[w_mem_idx][w_mem_way].ctr != '0) begin
            r_ent[w_mem_idx][w_mem_way].ctr <= r_ent[w_mem_idx][w_mem_way].ctr - 1'b1;
         end
      end else if (w_alloc) begin
         r_ent[w_mem_idx][w_wr_way] <= '{valid:  1'b1,
                                         tag:    w_mem_tag,
                                         target: mem_target,
                                         is_jal: mem_is_jal,
                                         ctr:    CTR_BITS'(1 << (CTR_BITS - 1))};
      end
   end

endmodule

// File: tb/tb_btb_bht_sa.sv
// Directed scoreboard bench for btb_bht_sa at default parameters (16 sets, 2 ways, 2-bit counters).
module tb_btb_bht_sa;
   import rv32i_types::*;

   logic         clk;
   logic         rst_n;
   logic [31:0]  if_pc, mem_pc, mem_target;
   logic         mem_update, mem_taken, mem_is_jal, flush_req;
   logic         flush_busy, hit, prediction, is_jal;
   logic [31:0]  target_out;
   flush_state_e dbg_state;

   // Lookup handshake: lk_valid marks a cycle whose outputs the monitor must check
   // against the head of exp_q; the driver pushes exactly one entry per such cycle.
   logic         lk_valid;
   logic [35:0]  exp_q[$];
   string        name_q[$];
   logic [35:0]  exp_v, act_v;
   string        cur_name;
   int           n_checks = 0;
   int           n_pass   = 0;

   btb_bht_sa dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_pc     (if_pc),
      .mem_pc    (mem_pc),
      .mem_target(mem_target),
      .mem_update(mem_update),
      .mem_taken (mem_taken),
      .mem_is_jal(mem_is_jal),
      .flush_req (flush_req),
      .flush_busy(flush_busy),
      .hit       (hit),
      .prediction(prediction),
      .target_out(target_out),
      .is_jal    (is_jal),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic jal);
      mem_pc     = pc;
      mem_target = tgt;
      mem_taken  = tk;
      mem_is_jal = jal;
      mem_update = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic jal);
      issue(pc, tgt, tk, jal);
      tick();
      mem_update = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic e_busy, input logic e_hit,
                         input logic e_pred, input logic e_jal, input logic [31:0] e_tgt,
                         input string nm);
      if_pc = pc;
      exp_q.push_back({e_busy, e_hit, e_pred, e_jal, e_tgt});
      name_q.push_back(nm);
      lk_valid = 1'b1;
      tick();
      lk_valid = 1'b0;
   endtask

   task automatic miss(input logic [31:0] pc, input string nm);
      lookup(pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, nm);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (lk_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL no_expect: lookup cycle with empty expected queue");
         end else begin
            exp_v    = exp_q.pop_front();
            cur_name = name_q.pop_front();
            act_v    = {flush_busy, hit, prediction, is_jal, target_out};
            if (act_v === exp_v) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got busy=%0b hit=%0b pred=%0b jal=%0b tgt=%h, want busy=%0b hit=%0b pred=%0b jal=%0b tgt=%h",
                        cur_name, act_v[35], act_v[34], act_v[33], act_v[32], act_v[31:0],
                        exp_v[35], exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      rst_n = 1'b0; if_pc = '0; mem_pc = '0; mem_target = '0;
      mem_update = 1'b0; mem_taken = 1'b0; mem_is_jal = 1'b0; flush_req = 1'b0;
      lk_valid = 1'b0;
      tick();
      miss(32'h100, "in_reset");
      rst_n = 1'b1;
      miss(32'h100, "post_reset");

      // Allocation, write visible only next cycle
      issue(32'h100, 32'h200, 1'b1, 1'b0);
      miss(32'h100, "same_cycle_old");
      mem_update = 1'b0;
      lookup(32'h100, 0, 1, 1, 0, 32'h200, "alloc_hit");

      // Counter walk: 2 ->1 ->0 ->0 ->1 ->2 ->3 ->3 ->2 ->1
      upd(32'h100, 32'h200, 0, 0); lookup(32'h100, 0, 1, 0, 0, 32'h200, "nt_1");
      upd(32'h100, 32'h200, 0, 0); lookup(32'h100, 0, 1, 0, 0, 32'h200, "nt_0");
      upd(32'h100, 32'h998, 0, 0); lookup(32'h100, 0, 1, 0, 0, 32'h200, "sat_low");
      upd(32'h100, 32'h200, 1, 0); lookup(32'h100, 0, 1, 0, 0, 32'h200, "t_from0");
      upd(32'h100, 32'h240, 1, 0); lookup(32'h100, 0, 1, 1, 0, 32'h240, "retarget");
      upd(32'h100, 32'h240, 1, 0); lookup(32'h100, 0, 1, 1, 0, 32'h240, "t_3");
      upd(32'h100, 32'h240, 1, 0); lookup(32'h100, 0, 1, 1, 0, 32'h240, "sat_t");
      upd(32'h100, 32'h998, 0, 0); lookup(32'h100, 0, 1, 1, 0, 32'h240, "sat_high");
      upd(32'h100, 32'h998, 0, 0); lookup(32'h100, 0, 1, 0, 0, 32'h240, "nt_after_sat");

      // Set 0 replacement: 0x100 way0, 0x140 way1, 0x180 evicts 0x100
      upd(32'h140, 32'h400, 1, 0);
      lookup(32'h140, 0, 1, 1, 0, 32'h400, "alloc_way1");
      lookup(32'h100, 0, 1, 0, 0, 32'h240, "way0_kept");
      upd(32'h180, 32'h480, 1, 0);
      miss(32'h100, "evict_lru");
      lookup(32'h140, 0, 1, 1, 0, 32'h400, "keep_140");
      lookup(32'h180, 0, 1, 1, 0, 32'h480, "alloc_180");
      upd(32'h140, 32'h400, 1, 0);
      upd(32'h1C0, 32'h600, 1, 0);
      miss(32'h180, "plru_evict");
      lookup(32'h140, 0, 1, 1, 0, 32'h400, "plru_keep");
      lookup(32'h1C0, 0, 1, 1, 0, 32'h600, "alloc_1c0");

      // Not-taken miss changes nothing, so the next allocation still evicts 0x140
      upd(32'h200, 32'h800, 0, 0);
      miss(32'h200, "nt_no_alloc");
      upd(32'h300, 32'h380, 1, 1);
      for (int i = 0; i < 4; i++) upd(32'h300, 32'h380, 0, 1);
      lookup(32'h300, 0, 1, 1, 1, 32'h380, "jal_pred");
      lookup(32'h1C0, 0, 1, 1, 0, 32'h600, "nt_miss_no_plru");
      miss(32'h140, "jal_evict");

      upd(32'h104, 32'h700, 1, 0);
      lookup(32'h104, 0, 1, 1, 0, 32'h700, "set1_hit");
      miss(32'h108, "set2_miss");

      // Flush: 16 busy cycles, updates and a re-request ignored during the sweep
      flush_req = 1'b1;
      lookup(32'h104, 0, 1, 1, 0, 32'h700, "pre_flush");
      flush_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         flush_req = (i == 10);
         issue(32'h500, 32'h900, 1'b1, 1'b0);
         lookup(32'h104, 1, 0, 0, 0, 32'h0, "sweep_busy");
      end
      mem_update = 1'b0;
      flush_req  = 1'b0;
      miss(32'h104, "flush_done");
      miss(32'h300, "flush_clr_300");
      miss(32'h1C0, "flush_clr_1c0");
      miss(32'h500, "sweep_upd_ignored");

      // Reset in sweep cycle 5
      upd(32'h104, 32'h700, 1, 0);
      flush_req = 1'b1;
      lookup(32'h104, 0, 1, 1, 0, 32'h700, "pre_flush2");
      flush_req = 1'b0;
      for (int i = 0; i < 5; i++) lookup(32'h104, 1, 0, 0, 0, 32'h0, "sweep2_busy");
      rst_n = 1'b0;
      miss(32'h104, "rst_mid_sweep");
      rst_n = 1'b1;
      miss(32'h104, "after_rst");
      upd(32'h100, 32'h200, 1, 0);
      lookup(32'h100, 0, 1, 1, 0, 32'h200, "post_rst_alloc");

      // Final report
      tick();
      tick();
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
